// File: rtl/sdram_cmd_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_cmd_issue_if
// Description : Command handshake and timing-status bundle between the SDRAM
//               main controller (master) and the command-issue stage (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_cmd_issue_if #(
  parameter int DW  = 16,
  parameter int RAW = 12
);

  logic                cmd_valid;
  logic [3:0]          cmd_type;
  logic [RAW-1:0]      cmd_addr;
  logic [1:0]          cmd_ba;
  logic [DW-1:0]       cmd_data;
  logic [DW/8-1:0]     cmd_dqm;
  logic                cmd_ready;
  logic                cmd_done;
  logic                precharge_ready;
  logic                active_ready;
  logic                write_ready;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_ba, cmd_data, cmd_dqm,
    input  cmd_ready, cmd_done, precharge_ready, active_ready, write_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_ba, cmd_data, cmd_dqm,
    output cmd_ready, cmd_done, precharge_ready, active_ready, write_ready
  );

endinterface
`default_nettype wire

// File: rtl/sdram_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module      : sdram_cmd_issue
// Description : SDRAM command-issue stage. Registers accepted commands onto
//               the SDRAM pins one cycle later and enforces tRP/tRCD/tRFC/tMRD
//               waits, tRAS, tRC, tWR and read-to-write DQ turnaround.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_cmd_issue #(
  parameter int CLK_FREQ = 100,
  parameter int DW       = 16,
  parameter int RAW      = 12,
  parameter int tRP      = 20,
  parameter int tRCD     = 20,
  parameter int tRFC     = 70,
  parameter int tRAS     = 42,
  parameter int tRC      = 60,
  parameter int tWR      = 15,
  parameter int cMRD     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sdram_cmd_issue_if.slave  ctrl,
  input  logic [2:0]        cfg_cas_latency,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [RAW-1:0]    sdram_addr,
  output logic [1:0]        sdram_ba,
  output logic [DW/8-1:0]   sdram_dqm,
  output logic [DW-1:0]     sdram_dq_out,
  output logic              sdram_dq_oe
);

  // Nanoseconds to clock cycles, rounded up.
  function automatic int f_ns2cyc(input int t_ns);
    return (t_ns * CLK_FREQ + 999) / 1000;
  endfunction

  function automatic int f_max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..v.
  function automatic int f_width(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

  localparam int c_RP   = f_max1(f_ns2cyc(tRP));
  localparam int c_RCD  = f_max1(f_ns2cyc(tRCD));
  localparam int c_RFC  = f_max1(f_ns2cyc(tRFC));
  localparam int c_RAS  = f_max1(f_ns2cyc(tRAS));
  localparam int c_RC   = f_max1(f_ns2cyc(tRC));
  localparam int c_WR   = f_ns2cyc(tWR);
  localparam int c_MRD  = f_max1(cMRD);

  localparam int c_RAS_LD   = c_RAS - 1;
  localparam int c_RC_LD    = c_RC - 1;
  localparam int c_WR_LD    = (c_WR > 0) ? c_WR - 1 : 0;
  localparam int c_WAIT_MAX = f_max(f_max(c_RP, c_RCD), f_max(c_RFC, c_MRD));

  localparam int WAIT_W = f_width(c_WAIT_MAX);
  localparam int RAS_W  = f_width(c_RAS_LD);
  localparam int RC_W   = f_width(c_RC_LD);
  localparam int WR_W   = f_width(c_WR_LD);
  // Read turnaround holds CL+1, CL being up to 7 on the 3-bit input.
  localparam int RD_W   = 4;

  localparam logic [3:0] c_CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] c_CMD_NOP     = 4'b0111;
  localparam logic [3:0] c_CMD_ACTIVE  = 4'b0011;
  localparam logic [3:0] c_CMD_READ    = 4'b0101;
  localparam logic [3:0] c_CMD_WRITE   = 4'b0100;
  localparam logic [3:0] c_CMD_PRE     = 4'b0010;
  localparam logic [3:0] c_CMD_REF     = 4'b0001;
  localparam logic [3:0] c_CMD_LMR     = 4'b0000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic [WAIT_W-1:0]   w_wait_load;
  logic                w_wait_done;

  logic [RAS_W-1:0]    r_ras_cnt;
  logic [RC_W-1:0]     r_rc_cnt;
  logic [WR_W-1:0]     r_wr_cnt;
  logic [RD_W-1:0]     r_rd_cnt;
  logic                r_rw_done;

  logic                w_is_act;
  logic                w_is_rd;
  logic                w_is_wr;
  logic                w_is_pre;
  logic                w_is_ref;
  logic                w_is_lmr;
  logic                w_is_timed;
  logic                w_accept;

  // Command decode; unrecognised encodings (NOP included) are never accepted.
  always_comb begin
    w_is_act   = (ctrl.cmd_type == c_CMD_ACTIVE);
    w_is_rd    = (ctrl.cmd_type == c_CMD_READ);
    w_is_wr    = (ctrl.cmd_type == c_CMD_WRITE);
    w_is_pre   = (ctrl.cmd_type == c_CMD_PRE);
    w_is_ref   = (ctrl.cmd_type == c_CMD_REF);
    w_is_lmr   = (ctrl.cmd_type == c_CMD_LMR);
    w_is_timed = w_is_act | w_is_pre | w_is_ref | w_is_lmr;
    w_accept   = ctrl.cmd_valid & (r_state == ST_IDLE) & (w_is_timed | w_is_rd | w_is_wr);
  end

  // Wait length selected by the command that opens the wait.
  always_comb begin
    w_wait_load = WAIT_W'(c_MRD);
    if (w_is_pre)      w_wait_load = WAIT_W'(c_RP);
    else if (w_is_act) w_wait_load = WAIT_W'(c_RCD);
    else if (w_is_ref) w_wait_load = WAIT_W'(c_RFC);
  end

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Next-state logic: timed commands block acceptance until their wait expires.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_wait_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_timed) begin
          w_state_nxt = ST_WAIT;
          w_wait_nxt  = w_wait_load;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt <= WAIT_W'(1)) begin
          w_wait_done = 1'b1;
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt  = r_wait_cnt - WAIT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Pin stage: accepted command one cycle later, NOP otherwise, INHIBIT in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= c_CMD_INHIBIT;
      sdram_addr   <= '0;
      sdram_ba     <= '0;
      sdram_dqm    <= '0;
      sdram_dq_out <= '0;
      sdram_dq_oe  <= 1'b0;
      r_rw_done    <= 1'b0;
    end else begin
      if (w_accept) begin
        {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= ctrl.cmd_type;
        sdram_addr <= ctrl.cmd_addr;
        sdram_ba   <= ctrl.cmd_ba;
        sdram_dqm  <= ctrl.cmd_dqm;
      end else begin
        {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= c_CMD_NOP;
      end
      sdram_dq_oe  <= w_accept & w_is_wr;
      sdram_dq_out <= (w_accept && w_is_wr) ? ctrl.cmd_data : '0;
      r_rw_done    <= w_accept & (w_is_rd | w_is_wr);
    end
  end

  // Row timing: tRAS and tRC both start at ACTIVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ras_cnt <= '0;
      r_rc_cnt  <= '0;
    end else begin
      if (w_accept && w_is_act) begin
        r_ras_cnt <= RAS_W'(c_RAS_LD);
        r_rc_cnt  <= RC_W'(c_RC_LD);
      end else begin
        if (r_ras_cnt != '0) r_ras_cnt <= r_ras_cnt - RAS_W'(1);
        if (r_rc_cnt  != '0) r_rc_cnt  <= r_rc_cnt  - RC_W'(1);
      end
    end
  end

  // Write recovery from WRITE; read-to-write turnaround from READ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_accept && w_is_wr)  r_wr_cnt <= WR_W'(c_WR_LD);
      else if (r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - WR_W'(1);

      if (w_accept && w_is_rd)  r_rd_cnt <= {1'b0, cfg_cas_latency} + RD_W'(1);
      else if (r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - RD_W'(1);
    end
  end

  assign sdram_cke            = 1'b1;
  assign ctrl.cmd_ready       = (r_state == ST_IDLE);
  assign ctrl.cmd_done        = rst_n & (w_wait_done | r_rw_done);
  assign ctrl.precharge_ready = (r_ras_cnt == '0) & (r_wr_cnt == '0);
  assign ctrl.active_ready    = (r_rc_cnt == '0);
  assign ctrl.write_ready     = (r_rd_cnt == '0);

endmodule
`default_nettype wire

// File: doc/sdram_cmd_issue.md
Name: sdram_cmd_issue

Overview:
Command-issue and timing-enforcement stage directly downstream of the SDRAM main controller. It accepts one internal command per handshake, registers it onto the SDRAM pins one cycle later, and enforces tRP/tRCD/tRFC/tMRD, tRAS, tRC, tWR and read-to-write DQ turnaround. It reports timing status back to the controller through cmd_ready, cmd_done, precharge_ready, active_ready and write_ready. cmd_type uses the 4-bit {cs_n,ras_n,cas_n,we_n} encoding:
- NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, REFRESH 0001, LOAD_MODE 0000.

Parameters:
CLK_FREQ, 100, clock frequency (MHz)
DW, 16, data width
RAW, 12, SDRAM address width
tRP, 20, (ns) precharge period
tRCD, 20, (ns) ACTIVE to READ/WRITE delay
tRFC, 70, (ns) refresh cycle time
tRAS, 42, (ns) ACTIVE to PRECHARGE minimum
tRC, 60, (ns) ACTIVE to ACTIVE minimum
tWR, 15, (ns) write recovery
cMRD, 2, (cycles) LOAD_MODE to next command

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command valid; accepted when cmd_valid & cmd_ready
cmd_type  in  4  command encoding (above)
cmd_addr  in  RAW  row, column or mode value; bit 10 = all-bank precharge
cmd_ba  in  2  bank
cmd_data  in  DW  write data
cmd_dqm  in  DW/8  byte mask
cfg_cas_latency  in  3  CAS latency, 2 or 3
cmd_ready  out  1  can accept a command this cycle
cmd_done  out  1  one-cycle pulse: command timing satisfied
precharge_ready  out  1  PRECHARGE is legal this cycle
active_ready  out  1  ACTIVE is legal this cycle
write_ready  out  1  WRITE is legal this cycle
sdram_cke  out  1  clock enable
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
sdram_addr  out  RAW  address pins
sdram_ba  out  2  bank pins
sdram_dqm  out  DW/8  mask pins
sdram_dq_out  out  DW  DQ drive value
sdram_dq_oe  out  1  DQ output enable

Behaviour:
- Cycle counts cX = ceil(tX*CLK_FREQ/1000), with a minimum of 1. cWR may be 0.
- Reset values: all command pins 1 (INHIBIT), addr/ba/dqm/dq_out 0, dq_oe 0, sdram_cke 1. State IDLE, all counters 0, cmd_done 0. Reset mid-wait aborts the wait immediately with no cmd_done pulse.
- Pin stage: a command accepted in cycle T appears on the pins in cycle T+1 (addr, ba and dqm registered with it). Any cycle without an accept drives NOP 0111.
- WRITE: dq_oe=1 and dq_out=cmd_data in T+1 only.
- FSM states: IDLE and WAIT. cmd_ready = (state==IDLE).
  - PRECHARGE, ACTIVE, REFRESH and LOAD_MODE accepted in IDLE: wait_cnt := N (cRP, cRCD, cRFC or cMRD), then go to WAIT.
  - In WAIT, wait_cnt decrements each cycle. When wait_cnt==1, cmd_done=1 and the next state is IDLE. cmd_done therefore pulses in T+N, cmd_ready is low T+1..T+N and high again at T+N+1.
  - READ and WRITE: state stays IDLE, so back-to-back accepts are allowed. cmd_done pulses in T+1.
- cmd_valid while cmd_ready=0, or with cmd_type NOP, is ignored: no pin change, no counter change.
- ras_cnt: loaded with cRAS-1 on ACTIVE accept, decrements to 0.
- wr_cnt: loaded with max(cWR-1,0) on WRITE accept, decrements to 0.
- precharge_ready = (ras_cnt==0) & (wr_cnt==0).
- rc_cnt: loaded with cRC-1 on ACTIVE accept. active_ready = (rc_cnt==0).
- rd_cnt: loaded with CL+1 on READ accept (CL from cfg_cas_latency). write_ready = (rd_cnt==0), so it is low T+1..T+CL+1. This gives one turnaround cycle after read data.
- A new load to any counter overrides its current value. Counters saturate at 0.
- All counters are sized from the largest value they can hold.
- The block does not check the sequencing legality of the upstream command stream.

Test Plan:
- Reset, then release: pins 1111, cke=1, cmd_ready=1, all *_ready=1, cmd_done=0.
- PRECHARGE accepted at T (100 MHz, cRP=2) -> pins 0010 with addr[10]=1 at T+1; cmd_ready low T+1..T+2; cmd_done pulse at T+2; NOP at T+2.
- ACTIVE at T (cRCD=2, cRAS=5, cRC=6) -> cmd_done at T+2; precharge_ready low T+1..T+4 and high at T+5; active_ready high at T+6.
- READ at T with CL=2, then WRITE requested -> write_ready low T+1..T+3; WRITE accepted at T+4 drives dq_oe=1 with data 0xA5A5 at T+5. With CL=3, write_ready is high at T+5.
- Back-to-back READs at T, T+1, T+2 -> cmd_ready stays 1; pins 0101 at T+1..T+3 with the correct columns; cmd_done pulses at T+1..T+3.
- REFRESH at T (cRFC=7) with reset asserted at T+3 -> pins INHIBIT from T+4, no cmd_done pulse, cmd_ready=1 after reset release.
